// File: rtl/sonata_pkg.sv
// Shared constants and types for the Sonata pinmux: selector width, register map
// landmarks and the block-signal positions used when wiring peripherals to the mux.
package sonata_pkg;

  localparam int PINMUX_SEL_W       = 8;
  localparam int PINMUX_IN_SEL_BASE = 128;
  localparam int PINMUX_LOCK_IDX    = 255;

  typedef logic [PINMUX_SEL_W-1:0] pinmux_sel_t;

  // Positions of peripheral signals on blk_out/blk_oe and blk_in.
  localparam int BLK_OUT_UART0_TX  = 0;
  localparam int BLK_OUT_UART1_TX  = 1;
  localparam int BLK_OUT_I2C0_SCL  = 2;
  localparam int BLK_OUT_I2C0_SDA  = 3;
  localparam int BLK_OUT_SPI0_SCK  = 4;
  localparam int BLK_OUT_SPI0_COPI = 5;
  localparam int BLK_OUT_SPI0_CS   = 6;
  localparam int BLK_OUT_GPIO_BASE = 32;

  localparam int BLK_IN_UART0_RX   = 0;
  localparam int BLK_IN_UART1_RX   = 1;
  localparam int BLK_IN_I2C0_SCL   = 2;
  localparam int BLK_IN_I2C0_SDA   = 3;
  localparam int BLK_IN_SPI0_CIPO  = 4;
  localparam int BLK_IN_GPIO_BASE  = 16;

endpackage

// File: rtl/sonata_pinmux_in_filter.sv
// One-bit input conditioner: 2-flop synchroniser, plus a debounce counter when
// PINMUX_INPUT_FILTER_EN is defined.
module sonata_pinmux_in_filter #(
  parameter int FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw,
  output logic filt
);

  if (FilterCycles < 1) begin : g_bad_cfg
    $error("FilterCycles must be at least 1");
  end

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], raw};
  end

`ifdef PINMUX_INPUT_FILTER_EN
  localparam int CntW = $clog2(FilterCycles + 1);

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  // The filtered value flips on the FilterCycles-th consecutive differing cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CntW'(FilterCycles - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[1];
`endif

endmodule

// File: rtl/sonata_pinmux_ctrl.sv
// Register-programmed pin multiplexer between peripheral IOs and board pins.
// Optional input debounce is enabled with PINMUX_INPUT_FILTER_EN.
module sonata_pinmux_ctrl
  import sonata_pkg::*;
#(
  parameter int                NumInPins     = 8,
  parameter int                NumOutPins    = 19,
  parameter int                NumInoutPins  = 68,
  parameter int                NumBlkOutputs = 64,
  parameter int                NumBlkInputs  = 32,
  parameter logic [NumBlkInputs-1:0] BlkInDefault = '1,
  parameter int                FilterCycles  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 reg_req_i,
  input  logic                                 reg_we_i,
  input  logic [9:0]                           reg_addr_i,
  input  logic [31:0]                          reg_wdata_i,
  output logic [31:0]                          reg_rdata_o,
  output logic                                 reg_rvalid_o,
  output logic                                 reg_err_o,
  input  logic [NumBlkOutputs-1:0]             blk_out_i,
  input  logic [NumBlkOutputs-1:0]             blk_oe_i,
  output logic [NumBlkInputs-1:0]              blk_in_o,
  input  logic [NumInPins+NumInoutPins-1:0]    pin_in_i,
  output logic [NumOutPins+NumInoutPins-1:0]   pin_out_o,
  output logic [NumOutPins+NumInoutPins-1:0]   pin_oe_o
);

  localparam int NumOutSel = NumOutPins + NumInoutPins;
  localparam int NumInSrc  = NumInPins + NumInoutPins;

  if (NumOutSel > 128) begin : g_bad_out
    $error("NumOutPins+NumInoutPins must not exceed 128");
  end
  if (NumBlkInputs > 127) begin : g_bad_in
    $error("NumBlkInputs must not exceed 127");
  end

  // Bus handshake: reg_req_i is a single-cycle request with no back-pressure;
  // each request yields exactly one reg_rvalid_o strobe on the following cycle,
  // carrying reg_rdata_o and reg_err_o.
  pinmux_sel_t out_sel_q [NumOutSel];
  pinmux_sel_t in_sel_q  [NumBlkInputs];
  logic        lock_q;

  logic [7:0]  idx;
  logic        hit_out, hit_in, hit_lock;
  logic        acc_err;
  pinmux_sel_t rd_val;
  logic        unused_bus;

  assign idx        = reg_addr_i[9:2];
  assign unused_bus = ^{reg_addr_i[1:0], reg_wdata_i[31:8]};

  always_comb begin
    hit_out  = idx < 8'(NumOutSel);
    hit_in   = (idx >= 8'(PINMUX_IN_SEL_BASE)) &&
               (idx < 8'(PINMUX_IN_SEL_BASE + NumBlkInputs));
    hit_lock = idx == 8'(PINMUX_LOCK_IDX);
    acc_err  = !(hit_out || hit_in || hit_lock) ||
               (reg_we_i && lock_q && (hit_out || hit_in));
    rd_val   = '0;
    for (int p = 0; p < NumOutSel; p++)
      if (idx == 8'(p)) rd_val = out_sel_q[p];
    for (int b = 0; b < NumBlkInputs; b++)
      if (idx == 8'(PINMUX_IN_SEL_BASE + b)) rd_val = in_sel_q[b];
    if (hit_lock) rd_val = {7'b0, lock_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_err_o    <= 1'b0;
      reg_rdata_o  <= '0;
      lock_q       <= 1'b0;
      for (int p = 0; p < NumOutSel; p++)    out_sel_q[p] <= '0;
      for (int b = 0; b < NumBlkInputs; b++) in_sel_q[b]  <= '0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      reg_err_o    <= reg_req_i && acc_err;
      reg_rdata_o  <= (reg_req_i && !reg_we_i) ? {24'b0, rd_val} : '0;
      if (reg_req_i && reg_we_i && hit_lock && reg_wdata_i[0]) lock_q <= 1'b1;
      if (reg_req_i && reg_we_i && !lock_q) begin
        for (int p = 0; p < NumOutSel; p++)
          if (idx == 8'(p)) out_sel_q[p] <= reg_wdata_i[7:0];
        for (int b = 0; b < NumBlkInputs; b++)
          if (idx == 8'(PINMUX_IN_SEL_BASE + b)) in_sel_q[b] <= reg_wdata_i[7:0];
      end
    end
  end

  // Output path; out-only pins always drive.
  always_comb begin
    pin_out_o = '0;
    pin_oe_o  = '0;
    for (int p = 0; p < NumOutSel; p++) begin
      for (int k = 0; k < NumBlkOutputs; k++) begin
        if (out_sel_q[p] == 8'(k + 1)) begin
          pin_out_o[p] = blk_out_i[k];
          pin_oe_o[p]  = blk_oe_i[k];
        end
      end
      if (p < NumOutPins) pin_oe_o[p] = 1'b1;
    end
  end

  logic [NumInSrc-1:0] pin_filt;

  for (genvar i = 0; i < NumInSrc; i++) begin : g_in_filter
    sonata_pinmux_in_filter #(
      .FilterCycles(FilterCycles)
    ) u_in_filter (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .raw   (pin_in_i[i]),
      .filt  (pin_filt[i])
    );
  end

  always_comb begin
    blk_in_o = BlkInDefault;
    for (int b = 0; b < NumBlkInputs; b++)
      for (int s = 0; s < NumInSrc; s++)
        if (in_sel_q[b] == 8'(s + 1)) blk_in_o[b] = pin_filt[s];
  end

endmodule
